mux_tree_pipe: RTL and testbench
================================

// Module: mux_tree_pipe
// PURPOSE
//  Parametrised, pipelined N:1 multiplexer built as a binary tree of 2:1 mux stages.
//  It generalises the fixed 1-bit 4:1 tree to WIDTH-bit channels and N_IN inputs.
//  A pipeline register sits after every tree level, with valid/ready flow control.
//  An optional auto-scan mode steps through the channels round-robin.
//  It sits between a bank of parallel sample sources and a single serial consumer.
// PARAMETERS
//  WIDTH   8  data bits per channel (>=1)
//  N_IN    8  number of input channels; power of two, >=2
//  SEL_W   $clog2(N_IN)  select width; also LEVELS = SEL_W = pipeline depth
// PORTS
//  clk        in   1            rising-edge clock, single clock domain
//  rst_n      in   1            synchronous reset, active-low
//  in_data    in   N_IN*WIDTH   channel k occupies bits [k*WIDTH +: WIDTH]
//  in_sel     in   SEL_W        channel select, used when scan_en=0
//  scan_en    in   1            1 = internal round-robin select, ignores in_sel
//  in_valid   in   1            in_data/in_sel valid this cycle
//  in_ready   out  1            block accepts a sample this cycle
//  out_data   out  WIDTH        selected channel data
//  out_chan   out  SEL_W        channel index that produced out_data
//  out_valid  out  1            out_data/out_chan valid
//  out_ready  in   1            consumer accepts out_data this cycle
// BEHAVIOUR
//  - Reset: on posedge clk with rst_n=0, clear every stage valid, data register,
//    channel-tag register and scan_cnt to 0. Resulting outputs: out_valid=0,
//    out_data=0, out_chan=0. in_ready=1 in the first cycle after reset.
//    Reset mid-stream discards all in-flight samples. No partial output is produced.
//  - Tree: level L (L=0..LEVELS-1) reduces 2^(LEVELS-L) words to 2^(LEVELS-L-1).
//    Level L selects with bit L of the effective select. Pair {2j+1,2j} is
//    chosen by sel[L] (0 picks the even word, 1 picks the odd word).
//  - Effective select: sel_eff = scan_en ? scan_cnt : in_sel. It is sampled at
//    acceptance and carried down the pipe with the data. sel bits are not re-read
//    later, so changing in_sel or scan_en after acceptance has no effect.
//  - Each stage registers its partial words, the remaining select bits,
//    the full SEL_W tag and a valid bit.
//  - Latency: exactly LEVELS cycles from acceptance to out_valid, provided there
//    is no backpressure. Throughput: 1 sample/cycle.
//  - Flow control: a single global stall. advance = !out_valid || out_ready.
//    in_ready = advance, a combinational function of out_valid and out_ready only.
//    Accept when in_valid && in_ready. All stages shift when advance=1.
//    When advance=1 and there is no acceptance, a bubble (valid=0) enters stage 0.
//    When advance=0 all stage registers hold, and out_data/out_chan stay stable
//    while out_valid=1.
//  - scan_cnt increments (mod N_IN, wrapping N_IN-1 -> 0) only on an accepted
//    sample with scan_en=1. It holds when scan_en=0. Toggling scan_en does not
//    reset the counter.
//  - No sample is dropped or duplicated. Samples leave in acceptance order.
//  - Simultaneous acceptance and output pop in one cycle is legal and normal.
//  - in_sel is always < N_IN (power-of-two N_IN), so there is no out-of-range case.
// TESTING
//  1 Reset: hold rst_n=0 for 3 cycles, with in_valid=1 and out_ready=1 throughout
//    -> out_valid=0, out_data=0, out_chan=0 during reset. First acceptance
//    occurs on the first cycle with rst_n=1.
//  2 Directed select, defaults: in_data channel k = 8'hA0+k. Send in_sel=5 for
//    1 cycle, out_ready=1 -> exactly 3 cycles later out_valid=1, out_data=8'hA5,
//    out_chan=5. A pulse of one cycle, then out_valid=0.
//  3 Streaming: in_sel=0..7 on consecutive cycles, with in_valid=1 and
//    out_ready=1 -> out_data=A0..A7 on 8 consecutive cycles, no gaps.
//  4 Backpressure: stream in_sel 1,2,3,4. Drop out_ready to 0 for 4 cycles once
//    the first output is valid -> in_ready=0 while stalled. out_data holds 8'hA1.
//    After release, A1,A2,A3,A4 appear in order, with none lost or repeated.
//  5 Auto-scan: scan_en=1, in_valid=1 for 10 cycles, out_ready=1 ->
//    out_chan = 0,1,...,7,0,1 with matching data. Then hold in_valid=0 for 2
//    cycles and resume -> the next out_chan is 2 (the counter held).
//  6 Reset mid-stream: assert rst_n=0 for 1 cycle while 3 samples are in flight
//    -> none of them ever appears on out_valid. scan_cnt restarts at 0.
//    The design also builds and passes test 2 with N_IN=2 and N_IN=16, WIDTH=1.

Source files
------------

// File: rtl/mux_tree_pipe_if.sv
// Handshake bundle for mux_tree_pipe: parallel sample bank on one side,
// single serial consumer on the other.
interface mux_tree_pipe_if #(
    parameter int WIDTH = 8,
    parameter int N_IN  = 8,
    parameter int SEL_W = $clog2(N_IN)
);
    logic [N_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]      in_sel;
    logic                  scan_en;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_chan;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_data, in_sel, scan_en, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  in_data, in_sel, scan_en, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/mux_tree_pipe.sv
// Pipelined N_IN:1 binary mux tree, one register stage per tree level, with a
// single global stall and an optional round-robin channel scanner.
module mux_tree_pipe #(
    parameter int WIDTH = 8,
    parameter int N_IN  = 8,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_tree_pipe_if.slave   bus
);
    localparam int LEVELS = SEL_W;
    // All level outputs packed back to back: level l owns N_IN>>(l+1) words.
    localparam int NWORDS = N_IN - 1;

    logic                    advance_s;
    logic                    accept_s;
    logic [SEL_W-1:0]        sel_eff_s;
    logic [SEL_W-1:0]        scan_cnt_r;
    logic [NWORDS*WIDTH-1:0] data_r;
    logic [NWORDS*WIDTH-1:0] data_nxt_s;
    logic [SEL_W-1:0]        tag_r [LEVELS];
    logic [LEVELS-1:0]       vld_r;

    // Word offset of level lvl's output group inside data_r.
    function automatic int roff(input int lvl);
        return N_IN - (N_IN >> lvl);
    endfunction

    // Global stall, acceptance and the select captured with the sample.
    always_comb begin
        advance_s = 1'b0;
        accept_s  = 1'b0;
        sel_eff_s = '0;
        if (!vld_r[LEVELS-1] || bus.out_ready) begin
            advance_s = 1'b1;
        end else begin
            advance_s = 1'b0;
        end
        accept_s = bus.in_valid && advance_s;
        if (bus.scan_en) begin
            sel_eff_s = scan_cnt_r;
        end else begin
            sel_eff_s = bus.in_sel;
        end
    end

    // 2:1 reductions feeding every stage; level l steers with tag bit l.
    always_comb begin
        data_nxt_s = data_r;
        for (int j = 0; j < (N_IN >> 1); j++) begin
            if (sel_eff_s[0]) begin
                data_nxt_s[(roff(0) + j)*WIDTH +: WIDTH] = bus.in_data[(2*j + 1)*WIDTH +: WIDTH];
            end else begin
                data_nxt_s[(roff(0) + j)*WIDTH +: WIDTH] = bus.in_data[(2*j)*WIDTH +: WIDTH];
            end
        end
        for (int l = 1; l < LEVELS; l++) begin
            for (int j = 0; j < (N_IN >> (l + 1)); j++) begin
                if (tag_r[l-1][l]) begin
                    data_nxt_s[(roff(l) + j)*WIDTH +: WIDTH] =
                        data_r[(roff(l-1) + 2*j + 1)*WIDTH +: WIDTH];
                end else begin
                    data_nxt_s[(roff(l) + j)*WIDTH +: WIDTH] =
                        data_r[(roff(l-1) + 2*j)*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Pipeline stages: shift together on advance, hold everything otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_r <= '0;
            vld_r  <= '0;
            for (int l = 0; l < LEVELS; l++) begin
                tag_r[l] <= '0;
            end
        end else if (advance_s) begin
            data_r   <= data_nxt_s;
            vld_r[0] <= accept_s;
            tag_r[0] <= sel_eff_s;
            for (int l = 1; l < LEVELS; l++) begin
                vld_r[l] <= vld_r[l-1];
                tag_r[l] <= tag_r[l-1];
            end
        end else begin
            data_r <= data_r;
            vld_r  <= vld_r;
        end
    end

    // Round-robin scanner; N_IN is a power of two so the add wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt_r <= '0;
        end else if (accept_s && bus.scan_en) begin
            scan_cnt_r <= scan_cnt_r + SEL_W'(1);
        end else begin
            scan_cnt_r <= scan_cnt_r;
        end
    end

    assign bus.in_ready  = advance_s;
    assign bus.out_data  = data_r[(NWORDS-1)*WIDTH +: WIDTH];
    assign bus.out_chan  = tag_r[LEVELS-1];
    assign bus.out_valid = vld_r[LEVELS-1];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed bench for mux_tree_pipe at default parameters (8 channels x 8 bits).
module tb_mux_tree_pipe;
    logic clk;
    logic rst_n;

    mux_tree_pipe_if #(.WIDTH(8), .N_IN(8)) bus ();

    mux_tree_pipe #(.WIDTH(8), .N_IN(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_checks;
    int          n_fail;
    int          cyc;
    logic [7:0]  pop_data [$];
    logic [2:0]  pop_chan [$];
    int          pop_cyc  [$];
    logic        seen_valid;
    logic        last_in_ready;
    logic        last_out_valid;
    logic [7:0]  last_out_data;
    logic        acc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle: drive, observe pre-edge handshake, step past the edge.
    task automatic cycle(input logic v, input logic [2:0] sel, input logic scan, input logic rdy);
        bus.in_valid  = v;
        bus.in_sel    = sel;
        bus.scan_en   = scan;
        bus.out_ready = rdy;
        #1;
        last_in_ready  = bus.in_ready;
        last_out_valid = bus.out_valid;
        last_out_data  = bus.out_data;
        acc = v && bus.in_ready;
        if (bus.out_valid === 1'b1) begin
            seen_valid = 1'b1;
            if (rdy) begin
                pop_data.push_back(bus.out_data);
                pop_chan.push_back(bus.out_chan);
                pop_cyc.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_log();
        pop_data.delete();
        pop_chan.delete();
        pop_cyc.delete();
        seen_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 3'd3, 1'b0, 1'b1);
            n_checks++;
            if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_chan !== 3'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: valid=%b data=%h chan=%0d, required 0/00/0",
                         bus.out_valid, bus.out_data, bus.out_chan);
            end
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
        end
        cycle(1'b1, 3'd3, 1'b0, 1'b1);
        cycle(1'b0, 3'd0, 1'b0, 1'b1);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_early: out_valid=%b, required 0", bus.out_valid);
        end
        cycle(1'b0, 3'd0, 1'b0, 1'b1);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA3 || bus.out_chan !== 3'd3) begin
            n_fail++;
            $display("FAIL reset_first_accept: valid=%b data=%h chan=%0d, required 1/a3/3",
                     bus.out_valid, bus.out_data, bus.out_chan);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, 1'b0, 1'b1);
    endtask

    task automatic test_directed();
        cycle(1'b1, 3'd5, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if (k == 3) begin
                if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 || bus.out_chan !== 3'd5) begin
                    n_fail++;
                    $display("FAIL directed_latency3: valid=%b data=%h chan=%0d, required 1/a5/5",
                             bus.out_valid, bus.out_data, bus.out_chan);
                end
            end else if (bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_pulse_k%0d: out_valid=%b, required 0", k, bus.out_valid);
            end
            cycle(1'b0, 3'd2, 1'b0, 1'b1);
        end
    endtask

    task automatic test_streaming();
        clear_log();
        for (int i = 0; i < 8; i++) cycle(1'b1, 3'(i), 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 3'd0, 1'b0, 1'b1);
        n_checks++;
        if (pop_data.size() != 8) begin
            n_fail++;
            $display("FAIL stream_count: got %0d outputs, required 8", pop_data.size());
        end
        for (int i = 0; i < 8; i++) begin
            if (i < pop_data.size()) begin
                n_checks++;
                if (pop_data[i] !== 8'hA0 + 8'(i) || pop_chan[i] !== 3'(i)
                    || pop_cyc[i] != pop_cyc[0] + i) begin
                    n_fail++;
                    $display("FAIL stream_item%0d: data=%h chan=%0d cyc_off=%0d, required %h/%0d/%0d",
                             i, pop_data[i], pop_chan[i], pop_cyc[i] - pop_cyc[0],
                             8'hA0 + 8'(i), i, i);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] sels [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
        int   idx        = 0;
        int   stall_left = 0;
        int   stalls     = 0;
        bit   started    = 1'b0;
        logic rdy;
        logic [2:0] s;
        clear_log();
        for (int c = 0; c < 20; c++) begin
            rdy = 1'b1;
            if (!started && bus.out_valid === 1'b1) begin
                started    = 1'b1;
                stall_left = 4;
            end
            if (stall_left > 0) rdy = 1'b0;
            s = (idx < 4) ? sels[idx] : 3'd0;
            cycle(idx < 4, s, 1'b0, rdy);
            if (!rdy) begin
                stalls++;
                n_checks++;
                if (last_in_ready !== 1'b0 || last_out_valid !== 1'b1 || last_out_data !== 8'hA1) begin
                    n_fail++;
                    $display("FAIL bp_stall%0d: in_ready=%b valid=%b data=%h, required 0/1/a1",
                             stalls, last_in_ready, last_out_valid, last_out_data);
                end
                stall_left--;
            end
            if (acc) idx++;
        end
        n_checks++;
        if (stalls != 4 || pop_data.size() != 4) begin
            n_fail++;
            $display("FAIL bp_count: stalls=%0d outputs=%0d, required 4/4", stalls, pop_data.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i < pop_data.size()) begin
                n_checks++;
                if (pop_data[i] !== 8'hA1 + 8'(i) || pop_chan[i] !== 3'(i + 1)) begin
                    n_fail++;
                    $display("FAIL bp_item%0d: data=%h chan=%0d, required %h/%0d",
                             i, pop_data[i], pop_chan[i], 8'hA1 + 8'(i), i + 1);
                end
            end
        end
    endtask

    task automatic test_autoscan();
        logic [2:0] exp_chan;
        clear_log();
        for (int i = 0; i < 10; i++) cycle(1'b1, 3'd7, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b0, 3'd7, 1'b1, 1'b1);
        cycle(1'b1, 3'd7, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 3'd0, 1'b0, 1'b1);
        n_checks++;
        if (pop_data.size() != 11) begin
            n_fail++;
            $display("FAIL scan_count: got %0d outputs, required 11", pop_data.size());
        end
        for (int i = 0; i < 11; i++) begin
            exp_chan = (i < 10) ? 3'(i % 8) : 3'd2;
            if (i < pop_data.size()) begin
                n_checks++;
                if (pop_chan[i] !== exp_chan || pop_data[i] !== 8'hA0 + 8'(exp_chan)) begin
                    n_fail++;
                    $display("FAIL scan_item%0d: chan=%0d data=%h, required %0d/%h",
                             i, pop_chan[i], pop_data[i], exp_chan, 8'hA0 + 8'(exp_chan));
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        clear_log();
        cycle(1'b1, 3'd6, 1'b1, 1'b1);
        cycle(1'b1, 3'd6, 1'b1, 1'b1);
        rst_n = 1'b0;
        cycle(1'b1, 3'd6, 1'b1, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) cycle(1'b0, 3'd0, 1'b0, 1'b1);
        n_checks++;
        if (seen_valid !== 1'b0 || pop_data.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_flush: seen_valid=%b outputs=%0d, required 0/0",
                     seen_valid, pop_data.size());
        end
        clear_log();
        cycle(1'b1, 3'd7, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 3'd0, 1'b0, 1'b1);
        n_checks++;
        if (pop_data.size() != 1) begin
            n_fail++;
            $display("FAIL midreset_scan_count: got %0d outputs, required 1", pop_data.size());
        end else if (pop_chan[0] !== 3'd0 || pop_data[0] !== 8'hA0) begin
            n_fail++;
            $display("FAIL midreset_scan_restart: chan=%0d data=%h, required 0/a0",
                     pop_chan[0], pop_data[0]);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        cyc           = 0;
        seen_valid    = 1'b0;
        acc           = 1'b0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sel    = 3'd0;
        bus.scan_en   = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) bus.in_data[k*8 +: 8] = 8'hA0 + 8'(k);

        test_reset();
        test_directed();
        test_streaming();
        test_backpressure();
        test_autoscan();
        test_reset_midstream();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
